// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit adder/subtractor resolving one CHUNK-bit slice per stage, with a
// global-stall valid/ready handshake and carry-out / signed-overflow flags.
module pipelined_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic             en;
    logic [WIDTH-1:0] beff;
    logic             c0;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign beff     = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_q, b_q, s_q;
        logic             c_q, v_q;
        logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
        logic             c_in, v_in;
        logic [CHUNK:0]   part;

        if (k == 0) begin : g_first
            assign a_in = a;
            assign b_in = beff;
            assign s_in = '0;
            assign c_in = c0;
            assign v_in = in_valid && in_ready;
        end else begin : g_next
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign s_in = g_stage[k-1].s_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
        end

        assign part = {1'b0, a_in[k*CHUNK +: CHUNK]} + {1'b0, b_in[k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in};

        // Lower result bits ride along; only this stage's slice is filled in.
        always_comb begin
            s_d                    = s_in;
            s_d[k*CHUNK +: CHUNK]  = part[CHUNK-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                a_q <= a_in;
                b_q <= b_in;
                s_q <= s_d;
                c_q <= part[CHUNK];
                v_q <= v_in;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].s_q;
    assign cout      = g_stage[STAGES-1].c_q;
    // Cleared registers give equal operand MSBs and a zero sum, so ovf is 0 out of reset.
    assign ovf       = (g_stage[STAGES-1].a_q[WIDTH-1] == g_stage[STAGES-1].b_q[WIDTH-1])
                    && (g_stage[STAGES-1].s_q[WIDTH-1] != g_stage[STAGES-1].a_q[WIDTH-1]);

    logic unused_lsbs;
    assign unused_lsbs = ^{g_stage[STAGES-1].a_q[WIDTH-2:0], g_stage[STAGES-1].b_q[WIDTH-2:0]};

endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ripple adder.
- Adds or subtracts two WIDTH-bit operands by splitting them into CHUNK-bit slices. One slice is resolved per pipeline stage, and the carry is registered between stages.
- Uses a valid/ready handshake on both sides, so it can sit between register-sliced datapath units (ALU/accumulator paths) at high clock rates.
- Also reports carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block accepts a beat this cycle.
- a, input, WIDTH, operand A (unsigned or two's complement).
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in; used only when sub=0.
- sub, input, 1, 0 = A+B+cin, 1 = A-B.
- out_valid, output, 1, result beat valid.
- out_ready, input, 1, downstream accepts the result.
- sum, output, WIDTH, result mod 2^WIDTH.
- cout, output, 1, carry out of the MSB; when sub=1, 1 means no borrow (A>=B unsigned).
- ovf, output, 1, signed two's-complement overflow.

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valid bits clear, and all data/carry registers clear.
  - Resulting outputs: out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 is permitted during and after reset, because the pipe is empty.
- Reset asserted mid-operation discards all in-flight beats. No partial result is ever presented.
- Arithmetic:
  - Effective B operand: Beff = sub ? ~b : b. Effective carry-in: c0 = sub ? 1 : cin.
  - Full result: {cout, sum} = a + Beff + c0, computed in WIDTH+1 bits.
  - ovf = (a[MSB] == Beff[MSB]) && (sum[MSB] != a[MSB]).
- Pipeline structure:
  - STAGES register stages, each carrying a valid bit.
  - Stage k (k=0..STAGES-1) adds slice k of A and Beff plus the carry registered from stage k-1 (c0 for k=0).
  - Stage k stores its CHUNK result bits and carry-out. It forwards the untouched upper slices of A and Beff, plus the lower result bits already computed.
  - Stage 0 captures a, Beff and c0 on acceptance.
  - The final stage holds sum, cout and ovf. ovf is evaluated from the captured A MSB, Beff MSB and final sum MSB.
- Handshake (global-stall pipeline):
  - Advance enable: en = !out_valid || out_ready. in_ready = en.
  - An input beat is accepted when in_valid && in_ready.
  - When en=1, every stage shifts one place. Stage 0's valid bit loads (in_valid && in_ready).
  - When en=0, all stages hold: data, carries and valid bits are frozen.
  - Bubbles are not compressed; they shift with the pipe.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+STAGES if out_ready stays high. Throughput is 1 beat per cycle.
- out_valid, sum, cout and ovf stay stable while out_valid && !out_ready.
- Simultaneous output consume and input accept in the same cycle are both legal; nothing is lost or duplicated.
- Ordering is strictly FIFO.
- Upstream inputs sampled while in_ready=0 are ignored.
- Degenerate case STAGES=1 (CHUNK=WIDTH) must work: a registered full adder with the same handshake.

Test Plan:
- Reset then single add (WIDTH=16, CHUNK=4): a=0x1234, b=0x0FFF, cin=1, sub=0, out_ready=1.
  - Required: out_valid asserted exactly 4 cycles after acceptance, sum=0x2234, cout=0, ovf=0.
- Carry ripple across all stages: a=0xFFFF, b=0x0000, cin=1.
  - Required: sum=0x0000, cout=1, ovf=0.
  - Also a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
  - Also a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
  - cin toggled during these beats has no effect.
- Back-to-back streaming: 20 random beats, in_valid=1 continuously, out_ready=1.
  - Required: one result per cycle after 4-cycle fill, in order, each matching a golden model.
- Backpressure: stream random beats while out_ready toggles pseudo-randomly, including long low periods.
  - Required: in_ready == (!out_valid || out_ready) every cycle.
  - Required: output held stable while stalled; no loss or duplication; order preserved.
- Reset mid-stream: assert rst_n=0 asynchronously (between clock edges) with 3 beats in flight.
  - Required: out_valid and outputs drop to 0 immediately.
  - Required: after release, the first result seen is from the first beat sent after reset.
